// File: rtl/max_tracker_3bit.sv
// Windowed maximum tracker for 3-bit samples with tie count and compare flags.
// Optional minimum tracking (run_min register, min_out port) is built when TRACK_MIN_EN is defined.
module max_tracker_3bit #(
  parameter int unsigned WINDOW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] max_out,
`ifdef TRACK_MIN_EN
  output logic [2:0] min_out,
`endif
  output logic [3:0] tie_cnt,
  output logic       cmp_gt,
  output logic       cmp_eq,
  output logic       cmp_lt,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 3;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ties;
  logic [DW-1:0] run_max;

  logic          accept;
  logic          a_gt;
  logic          a_eq;
  logic          a_lt;
  logic [DW-1:0] upd_max;
  logic [CW-1:0] upd_ties;
  logic [CW-1:0] upd_cnt;
  logic          done;

`ifdef TRACK_MIN_EN
  logic [DW-1:0] run_min;
  logic [DW-1:0] upd_min;
`endif

  // Window state as it will stand once the current sample is absorbed
  always_comb begin
    accept   = in_valid && in_ready;
    a_gt     = in_data > run_max;
    a_eq     = in_data == run_max;
    a_lt     = in_data < run_max;
    upd_max  = run_max;
    upd_ties = ties;
    upd_cnt  = cnt + CW'(1);
    if (state == IDLE) begin
      upd_max  = in_data;
      upd_ties = CW'(1);
      upd_cnt  = CW'(1);
    end else if (a_gt) begin
      upd_max  = in_data;
      upd_ties = CW'(1);
    end else if (a_eq) begin
      upd_ties = ties + CW'(1);
    end
    done = upd_cnt == CW'(WINDOW);
  end

`ifdef TRACK_MIN_EN
  always_comb begin
    upd_min = run_min;
    if (state == IDLE || in_data < run_min) upd_min = in_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ties      <= '0;
      run_max   <= '0;
      max_out   <= '0;
      tie_cnt   <= '0;
      cmp_gt    <= 1'b0;
      cmp_eq    <= 1'b0;
      cmp_lt    <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef TRACK_MIN_EN
      run_min   <= '1;
      min_out   <= '1;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            run_max <= upd_max;
            ties    <= upd_ties;
            cnt     <= upd_cnt;
`ifdef TRACK_MIN_EN
            run_min <= upd_min;
`endif
            // First sample of a window has nothing to compare against
            if (state == IDLE) begin
              cmp_gt <= 1'b0;
              cmp_eq <= 1'b1;
              cmp_lt <= 1'b0;
            end else begin
              cmp_gt <= a_gt;
              cmp_eq <= a_eq;
              cmp_lt <= a_lt;
            end
            if (done) begin
              max_out   <= upd_max;
              tie_cnt   <= upd_ties;
`ifdef TRACK_MIN_EN
              min_out   <= upd_min;
`endif
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_tracker_3bit.sv
// Directed self-checking bench for max_tracker_3bit (WINDOW=4).
// Minimum checks are compiled only when TRACK_MIN_EN is defined.
module tb_max_tracker_3bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] max_out;
  logic [3:0] tie_cnt;
  logic       cmp_gt;
  logic       cmp_eq;
  logic       cmp_lt;
  logic       out_valid;
  logic       out_ready;
`ifdef TRACK_MIN_EN
  logic [2:0] min_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  max_tracker_3bit #(.WINDOW(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .max_out(max_out),
`ifdef TRACK_MIN_EN
    .min_out(min_out),
`endif
    .tie_cnt(tie_cnt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 3'd5; out_ready = 1'b0;
    step(); step();
    n_cmp++;
    if ({out_valid, max_out, tie_cnt, cmp_gt, cmp_eq, cmp_lt} !== 11'b0) begin
      n_bad++; $display("FAIL reset_outs got v=%0d max=%0d tie=%0d gel=%b%b%b want all 0",
                        out_valid, max_out, tie_cnt, cmp_gt, cmp_eq, cmp_lt);
    end
`ifdef TRACK_MIN_EN
    n_cmp++;
    if (min_out !== 3'd7) begin n_bad++; $display("FAIL reset_min got %0d want 7", min_out); end
`endif
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0d want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(3'd5); send(3'd7); send(3'd3);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %0d want 0", out_valid); end
    send(3'd7);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency got %0d want 1", out_valid); end
    n_cmp++;
    if (max_out !== 3'd7 || tie_cnt !== 4'd2) begin
      n_bad++; $display("FAIL basic_result got max=%0d tie=%0d want max=7 tie=2", max_out, tie_cnt);
    end
    n_cmp++;
    if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b010) begin
      n_bad++; $display("FAIL basic_cmp got %b%b%b want 010", cmp_gt, cmp_eq, cmp_lt);
    end
`ifdef TRACK_MIN_EN
    n_cmp++;
    if (min_out !== 3'd3) begin n_bad++; $display("FAIL basic_min got %0d want 3", min_out); end
`endif
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL basic_exit got valid=%0d ready=%0d want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_cmp();
    out_ready = 1'b1;
    send(3'd5);
    n_cmp++;
    if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b010) begin
      n_bad++; $display("FAIL cmp_first got %b%b%b want 010", cmp_gt, cmp_eq, cmp_lt);
    end
    send(3'd7);
    n_cmp++;
    if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b100) begin
      n_bad++; $display("FAIL cmp_gt got %b%b%b want 100", cmp_gt, cmp_eq, cmp_lt);
    end
    send(3'd1);
    n_cmp++;
    if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b001) begin
      n_bad++; $display("FAIL cmp_lt got %b%b%b want 001", cmp_gt, cmp_eq, cmp_lt);
    end
    step(); step();
    n_cmp++;
    if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b001 || out_valid !== 1'b0 || max_out !== 3'd7) begin
      n_bad++; $display("FAIL cmp_hold got %b%b%b valid=%0d max=%0d want 001 0 7",
                        cmp_gt, cmp_eq, cmp_lt, out_valid, max_out);
    end
    send(3'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || max_out !== 3'd7 || tie_cnt !== 4'd1) begin
      n_bad++; $display("FAIL cmp_result got valid=%0d max=%0d tie=%0d want 1 7 1", out_valid, max_out, tie_cnt);
    end
`ifdef TRACK_MIN_EN
    n_cmp++;
    if (min_out !== 3'd0) begin n_bad++; $display("FAIL cmp_min got %0d want 0", min_out); end
`endif
    step();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send(3'd2); send(3'd2); send(3'd2); send(3'd2);
    in_valid = 1'b1; in_data = 3'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || max_out !== 3'd2 || tie_cnt !== 4'd4) begin
        n_bad++; $display("FAIL hold_%0d got valid=%0d ready=%0d max=%0d tie=%0d want 1 0 2 4",
                          i, out_valid, in_ready, max_out, tie_cnt);
      end
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL hold_exit got valid=%0d ready=%0d want 0/1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    send(3'd1); send(3'd1); send(3'd1); send(3'd1);
    n_cmp++;
    if (out_valid !== 1'b1 || max_out !== 3'd1 || tie_cnt !== 4'd4) begin
      n_bad++; $display("FAIL back_to_back got valid=%0d max=%0d tie=%0d want 1 1 4", out_valid, max_out, tie_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(3'd7); send(3'd7);
    rst = 1'b1; in_valid = 1'b1; in_data = 3'd7;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, max_out, tie_cnt, cmp_gt, cmp_eq, cmp_lt} !== 11'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_outs got v=%0d max=%0d tie=%0d gel=%b%b%b ready=%0d want 0s ready 1",
                        out_valid, max_out, tie_cnt, cmp_gt, cmp_eq, cmp_lt, in_ready);
    end
    send(3'd1); send(3'd0); send(3'd6); send(3'd6);
    n_cmp++;
    if (out_valid !== 1'b1 || max_out !== 3'd6 || tie_cnt !== 4'd2) begin
      n_bad++; $display("FAIL rstmid_result got valid=%0d max=%0d tie=%0d want 1 6 2", out_valid, max_out, tie_cnt);
    end
`ifdef TRACK_MIN_EN
    n_cmp++;
    if (min_out !== 3'd0) begin n_bad++; $display("FAIL rstmid_min got %0d want 0", min_out); end
`endif
    // Reset while a result is held must win over the handshake
    out_ready = 1'b0;
    step();
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || max_out !== 3'd0 || tie_cnt !== 4'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rsthold got valid=%0d max=%0d tie=%0d ready=%0d want 0 0 0 1",
                        out_valid, max_out, tie_cnt, in_ready);
    end
  endtask

  task automatic test_gaps();
    logic [2:0] dat [7];
    logic       vld [7];
    dat = '{3'd4, 3'd7, 3'd7, 3'd0, 3'd6, 3'd7, 3'd6};
    vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vld[i]; in_data = dat[i];
      step();
      if (i < 6) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gaps_early_%0d got %0d want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || max_out !== 3'd6 || tie_cnt !== 4'd2) begin
      n_bad++; $display("FAIL gaps_result got valid=%0d max=%0d tie=%0d want 1 6 2", out_valid, max_out, tie_cnt);
    end
`ifdef TRACK_MIN_EN
    n_cmp++;
    if (min_out !== 3'd0) begin n_bad++; $display("FAIL gaps_min got %0d want 0", min_out); end
`endif
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_cmp();
    test_hold();
    test_reset_mid();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max_tracker_3bit.md
MAX_TRACKER_3BIT -- requirements
Module: max_tracker_3bit

Interface
REQ-001 Parameter: WINDOW, default 4, number of samples per window; legal range 2..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  3  unsigned sample.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 max_out  output  3  largest sample of the completed window.
REQ-008 min_out  output  3  smallest sample of the completed window; present only under TRACK_MIN_EN.
REQ-009 tie_cnt  output  4  number of window samples equal to max_out.
REQ-010 cmp_gt, cmp_eq, cmp_lt  output  1 each  registered result of the last accepted sample versus the running max before update (A>B, A=B, A<B).
REQ-011 out_valid  output  1  window result valid.
REQ-012 out_ready  input  1  consumer takes the result.

Function
REQ-013 A sample SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-014 States: IDLE (no sample in window), ACCUM (1..WINDOW-1 samples held), HOLD (result presented).
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-016 IDLE, accept: run_max<=in_data, run_min<=in_data, ties<=1, cnt<=1, cmp_eq<=1, cmp_gt<=0, cmp_lt<=0; next state ACCUM. With WINDOW=1 excluded, IDLE SHALL never go directly to HOLD.
REQ-017 ACCUM, accept: compare in_data (A) with run_max (B). gt -> run_max<=A, ties<=1. eq -> ties<=ties+1. lt -> no max change. run_min SHALL take A when A<run_min. cnt<=cnt+1.
REQ-018 Exactly one of cmp_gt/cmp_eq/cmp_lt SHALL be 1 after the first accept; they SHALL hold their value until the next accept.
REQ-019 When the accept brings cnt to WINDOW, max_out/min_out/tie_cnt SHALL load the updated values (including that sample) and out_valid SHALL rise on the next cycle; state HOLD.
REQ-020 Latency: one cycle from the final accepted sample to out_valid=1.
REQ-021 HOLD: out_valid, max_out, min_out and tie_cnt SHALL stay stable until out_ready=1; on that cycle, transition to IDLE, clear cnt, out_valid<=0 next cycle.
REQ-022 No sample SHALL be accepted on the HOLD-exit cycle; the earliest next accept is the following cycle.
REQ-023 in_valid=0 in ACCUM SHALL leave all state unchanged (no timeout).
REQ-024 max_out/min_out/tie_cnt SHALL change only on window completion.
REQ-025 Arithmetic unsigned; tie_cnt saturation is not needed (max WINDOW=15 fits in 4 bits).

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, cnt=0, run_max=0, run_min=7, ties=0, max_out=0, min_out=7, tie_cnt=0, cmp_gt=0, cmp_eq=0, cmp_lt=0, out_valid=0.
REQ-027 Reset SHALL take priority over every accept and handshake in the same cycle, including mid-window and in HOLD; the partial window SHALL be discarded.
REQ-028 in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-029 Macro TRACK_MIN_EN defined: run_min register and the min_out port SHALL exist and behave as in REQ-017/019/026.
REQ-030 TRACK_MIN_EN undefined: min_out port and run_min logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 WINDOW=4, samples 5,7,3,7, out_ready=1 -> out_valid one cycle after the 4th sample; max_out=7, tie_cnt=2, min_out=3; cmp after the 4th sample is eq=1.
REQ-032 Samples 5 then 7 -> after the 2nd accept cmp_gt=1. Then 1 -> cmp_lt=1, run_max still 7.
REQ-033 Window 2,2,2,2 completes, out_ready=0 for 5 cycles -> out_valid held, in_ready=0, a sample offered with in_valid=1 is not taken; max_out=2, tie_cnt=4; out_ready=1 -> IDLE.
REQ-034 rst pulsed after 2 of 4 samples -> all outputs at reset values; next 4 samples 1,0,6,6 produce max_out=6, tie_cnt=2, min_out=0.
REQ-035 in_valid toggling 1,0,0,1,1,0,1 with samples 4,x,x,0,6,x,6 -> 4 accepted; max_out=6, tie_cnt=2.
REQ-036 Build without TRACK_MIN_EN, rerun REQ-031 -> max_out=7, tie_cnt=2, no min_out port.
